shreg_arbiter: RTL and testbench
================================

# shreg_arbiter

Round-robin arbiter and sequencer that shares one W-bit falling-edge storage register among N requesters. Each granted requester's data is captured into the register, held stable for a fixed number of clock periods, then released. The block sits between several producer blocks and the single shared negative-edge data register. It owns all write sequencing for that register.

## Interface
- `N`, default 4: number of requesters, at least 2.
- `W`, default 8: data width.
- `HOLD`, default 2: clock periods each grant, and the captured value, is held. Must be at least 1.

- `ck`  in  1  clock; all state changes on the falling edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  N  request, one bit per requester; level-sensitive.
- `din`  in  N*W  requester data, flattened; requester i occupies `din[i*W +: W]`.
- `q`  out  W  shared register contents; reset value 0.
- `gnt`  out  N  one-hot grant, or all zero; reset value 0.
- `busy`  out  1  high while a grant is active; reset value 0.
- `done`  out  1  one-period pulse at grant release; reset value 0.

## Operation
- All outputs are registered.
- Internal state:
  - FSM with states IDLE and HOLD.
  - Round-robin pointer `ptr`, width clog2(N), reset 0.
  - Hold counter `cnt`, width clog2(HOLD), minimum 1 bit, reset 0.
- IDLE, at a falling edge with `req != 0`:
  - Winner w = first set bit of `req` searching upward from `ptr`, wrapping from N-1 to 0.
  - `q <= din[w]`, `gnt <= 1<<w`, `busy <= 1`, `cnt <= HOLD-1`.
  - `ptr <= (w+1) mod N`.
  - Next state HOLD.
- IDLE with `req == 0`: no change. `done <= 0`.
- HOLD, at each falling edge:
  - If `cnt == 0`: `gnt <= 0`, `busy <= 0`, `done <= 1`, next state IDLE.
  - Otherwise `cnt <= cnt-1`.
- `done` is cleared at every edge where it is not being set.
- During HOLD:
  - `req` and `din` are ignored.
  - A requester dropping `req` does not shorten its grant.
  - `q` never changes.
- Every grant is followed by at least one IDLE period; there is no back-to-back re-grant.
- `q` keeps its last captured value after release, until the next grant.
- Reset (`rst_n` low) takes effect immediately, independent of `ck`, and applies in any state including mid-HOLD:
  - state IDLE;
  - `q`, `gnt`, `busy`, `done`, `ptr`, `cnt` all 0.
- Reset deassertion is sampled at the next falling edge. The first grant is possible at the first falling edge after `rst_n` goes high.

## Timing
- Request to grant: `gnt`, `q` and `busy` update at the first falling edge where `req` is sampled non-zero in IDLE. Latency is 0 to 1 periods depending on request arrival.
- Grant width: `gnt` and `busy` are high for exactly HOLD periods. They are set at edge E0 and cleared at edge E(HOLD).
- `done` is high from E(HOLD) to E(HOLD+1).
- Earliest next grant is at E(HOLD+1). Saturated throughput is one grant per HOLD+1 periods.
- Simultaneous requests resolve by `ptr` only. There is no fixed priority.
- The pointer wraps from N-1 to 0.

## Structure
- Shared package `shreg_pkg`:
  - state encoding localparams `ST_IDLE = 0`, `ST_HOLD = 1`;
  - the clog2 helper function used for the `ptr` and `cnt` widths.
- Sub-module `rr_pick`: combinational.
  - Inputs: `req[N]`, `ptr`.
  - Outputs: `win` index and `any` flag.
  - Implemented as a rotate, priority-encode, rotate-back.
- Top level contains the FSM, the counter, the pointer and the capture register.

## Test plan
All scenarios use N=4, W=8, HOLD=2, with a free-running `ck` at a 100-unit period.
- Reset idle: hold `rst_n` low for 2 periods. Check `q = 00`, `gnt = 0000`, `busy = 0`, `done = 0`. Release with `req = 0000`: outputs remain 0 for 5 periods.
- Single request: `req = 0010`, `din[1] = A5`.
  - At the next falling edge: `gnt = 0010`, `q = A5`, `busy = 1`.
  - Two edges later: `gnt = 0000`, `done = 1` for one period.
  - `q` stays `A5` afterwards.
- Saturated fairness: `req = 1111` held, `din[i] = 10+i`.
  - Grants in order `0001`, `0010`, `0100`, `1000`, `0001`, each starting 3 periods apart.
  - `q` takes the values 10, 11, 12, 13, 10 in turn.
- Wrap: after a grant to requester 2, apply `req = 1001`. Grant goes to 3, then 0.
- Hold integrity: grant requester 0 with `din[0] = 3C`. During HOLD, drop `req[0]` and change `din[0]` to `FF`. Check `gnt = 0001` for the full 2 periods and `q` stays `3C`.
- Reset mid-hold: assert `rst_n` low between falling edges during HOLD. Check `q`, `gnt` and `busy` go to 0 before the next edge. After release, `req = 1111` grants requester 0 first (`ptr` was reset to 0).

Source files
------------

// File: rtl/shreg_pkg.sv
// Shared definitions for the shared-register arbiter: state encoding and width helper.
package shreg_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_HOLD = 1'b1;

  typedef enum logic {
    S_IDLE = ST_IDLE,
    S_HOLD = ST_HOLD
  } state_e;

  // ceil(log2(value)), never less than one bit so 1-valued widths stay legal.
  function automatic int clog2_min1(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/shreg_arbiter_rr_pick.sv
// Combinational round-robin picker: rotate requests by ptr, take the lowest set bit, rotate back.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] win,
  output logic          any
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [PW-1:0]  off;
  logic [PW:0]    sum;

  always_comb begin
    dbl = {req, req};
    rot = dbl[ptr +: N];
    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = PW'(i);
    end
    any = |req;
    // Rotate back: offset from ptr, reduced modulo N.
    sum = {1'b0, off} + {1'b0, ptr};
    if (sum >= (PW + 1)'(N)) sum = sum - (PW + 1)'(N);
    win = sum[PW-1:0];
  end

endmodule

// File: rtl/shreg_arbiter.sv
// Round-robin sequencer owning a shared falling-edge data register; each grant holds for HOLD periods.
module shreg_arbiter
  import shreg_pkg::*;
#(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int HOLD = 2
) (
  input  logic           ck,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] din,
  output logic [W-1:0]   q,
  output logic [N-1:0]   gnt,
  output logic           busy,
  output logic           done
);

  localparam int PW = clog2_min1(N);
  localparam int CW = clog2_min1(HOLD);

  state_e        state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  q_q, q_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [PW-1:0] win;
  logic          any;
  logic [W-1:0]  din_win;
  logic [N-1:0]  gnt_win;

  rr_pick #(.N(N), .PW(PW)) u_pick (
    .req (req),
    .ptr (ptr_q),
    .win (win),
    .any (any)
  );

  always_comb begin
    din_win = '0;
    gnt_win = '0;
    for (int i = 0; i < N; i++) begin
      if (win == PW'(i)) begin
        din_win    = din[i*W +: W];
        gnt_win[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    gnt_d   = gnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (any) begin
          q_d     = din_win;
          gnt_d   = gnt_win;
          busy_d  = 1'b1;
          cnt_d   = CW'(HOLD - 1);
          ptr_d   = (win == PW'(N - 1)) ? '0 : win + PW'(1);
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        // Requests and data are ignored here; only the counter decides release.
        if (cnt_q == '0) begin
          gnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(negedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign q    = q_q;
  assign gnt  = gnt_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_shreg_arbiter.sv
// Scoreboard bench for shreg_arbiter (N=4, W=8, HOLD=2): stimulus queues expected grants, a monitor checks them.
module tb_shreg_arbiter;

  localparam int N    = 4;
  localparam int W    = 8;
  localparam int HOLD = 2;

  logic           ck;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] din;
  logic [W-1:0]   q;
  logic [N-1:0]   gnt;
  logic           busy;
  logic           done;

  typedef struct packed {
    logic [N-1:0] gnt;
    logic [W-1:0] q;
  } exp_t;

  exp_t exp_q[$];
  int   start_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  shreg_arbiter #(.N(N), .W(W), .HOLD(HOLD)) dut (
    .ck    (ck),
    .rst_n (rst_n),
    .req   (req),
    .din   (din),
    .q     (q),
    .gnt   (gnt),
    .busy  (busy),
    .done  (done)
  );

  initial ck = 1'b0;
  always #50 ck = ~ck;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, expv, $time);
    end
  endtask

  task automatic set_din(input int i, input logic [W-1:0] v);
    din[i*W +: W] = v;
  endtask

  task automatic expect_grant(input logic [N-1:0] g, input logic [W-1:0] v);
    exp_t e;
    e.gnt = g;
    e.q   = v;
    exp_q.push_back(e);
  endtask

  // Step to just after the next rising edge, safely between falling edges.
  task automatic step();
    @(posedge ck);
    #5;
  endtask

  // Monitor: samples mid-period, pops an expectation at every grant start,
  // and checks hold width, q/gnt stability and the done pulse.
  initial begin
    logic         prev_busy;
    int           run;
    logic [W-1:0] held_q;
    logic [N-1:0] held_gnt;
    exp_t         e;
    prev_busy = 1'b0;
    run       = 0;
    held_q    = '0;
    held_gnt  = '0;
    forever begin
      @(posedge ck);
      cyc++;
      if (!rst_n) begin
        prev_busy = 1'b0;
        run       = 0;
      end else begin
        if (busy && !prev_busy) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_grant: got gnt=%b q=%h with no grant expected", gnt, q);
          end else begin
            e = exp_q.pop_front();
            chk("grant_gnt", 32'(gnt), 32'(e.gnt));
            chk("grant_q", 32'(q), 32'(e.q));
          end
          start_q.push_back(cyc);
          run      = 1;
          held_q   = q;
          held_gnt = gnt;
        end else if (busy) begin
          run++;
          chk("hold_q_stable", 32'(q), 32'(held_q));
          chk("hold_gnt_stable", 32'(gnt), 32'(held_gnt));
        end else if (prev_busy) begin
          chk("hold_width", 32'(run), 32'(HOLD));
          chk("done_pulse", 32'(done), 32'd1);
          chk("gnt_released", 32'(gnt), 32'd0);
          chk("q_kept_after_release", 32'(q), 32'(held_q));
        end else begin
          chk("done_idle", 32'(done), 32'd0);
        end
        chk("busy_vs_gnt", 32'(busy), 32'(gnt != '0));
        prev_busy = busy;
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    req   = '0;
    din   = '0;

    // Reset idle
    repeat (2) step();
    chk("rst_q", 32'(q), 32'h00);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("idle_gnt", 32'(gnt), 32'h0);
      chk("idle_q", 32'(q), 32'h00);
      chk("idle_busy", 32'(busy), 32'd0);
    end

    // Saturated fairness from ptr=0
    start_q.delete();
    for (int i = 0; i < N; i++) set_din(i, 8'h10 + 8'(i));
    expect_grant(4'b0001, 8'h10);
    expect_grant(4'b0010, 8'h11);
    expect_grant(4'b0100, 8'h12);
    expect_grant(4'b1000, 8'h13);
    expect_grant(4'b0001, 8'h10);
    req = 4'b1111;
    repeat (13) step();
    req = 4'b0000;
    repeat (4) step();
    chk("sat_grant_count", 32'(start_q.size()), 32'd5);
    for (int k = 1; k < start_q.size(); k++)
      chk("sat_spacing", 32'(start_q[k] - start_q[k-1]), 32'd3);

    // Single request (ptr=1 after saturation)
    set_din(1, 8'hA5);
    expect_grant(4'b0010, 8'hA5);
    req = 4'b0010;
    step();
    chk("single_gnt", 32'(gnt), 32'b0010);
    chk("single_q", 32'(q), 32'hA5);
    chk("single_busy", 32'(busy), 32'd1);
    req = 4'b0000;
    step();
    step();
    chk("single_rel_gnt", 32'(gnt), 32'h0);
    chk("single_done", 32'(done), 32'd1);
    step();
    chk("single_done_clear", 32'(done), 32'd0);
    chk("single_q_kept", 32'(q), 32'hA5);
    repeat (2) step();

    // Wrap: grant 2, then 1001 resolves to 3 then 0
    set_din(2, 8'h22);
    expect_grant(4'b0100, 8'h22);
    req = 4'b0100;
    step();
    req = 4'b0000;
    repeat (3) step();
    set_din(3, 8'h33);
    set_din(0, 8'h44);
    expect_grant(4'b1000, 8'h33);
    expect_grant(4'b0001, 8'h44);
    req = 4'b1001;
    repeat (4) step();
    req = 4'b0000;
    repeat (4) step();

    // Hold integrity
    set_din(0, 8'h3C);
    expect_grant(4'b0001, 8'h3C);
    req = 4'b0001;
    step();
    chk("hold_gnt0", 32'(gnt), 32'b0001);
    chk("hold_q0", 32'(q), 32'h3C);
    req = 4'b0000;
    set_din(0, 8'hFF);
    step();
    chk("hold_gnt1", 32'(gnt), 32'b0001);
    chk("hold_q1", 32'(q), 32'h3C);
    chk("hold_busy1", 32'(busy), 32'd1);
    step();
    chk("hold_rel_gnt", 32'(gnt), 32'h0);
    chk("hold_rel_q", 32'(q), 32'h3C);
    repeat (2) step();

    // Reset mid-hold
    set_din(2, 8'h77);
    expect_grant(4'b0100, 8'h77);
    req = 4'b0100;
    step();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    req   = 4'b0000;
    #5;
    chk("midrst_q", 32'(q), 32'h00);
    chk("midrst_gnt", 32'(gnt), 32'h0);
    chk("midrst_busy", 32'(busy), 32'd0);
    step();
    for (int i = 0; i < N; i++) set_din(i, 8'h50 + 8'(i));
    expect_grant(4'b0001, 8'h50);
    rst_n = 1'b1;
    req   = 4'b1111;
    step();
    chk("post_rst_gnt", 32'(gnt), 32'b0001);
    chk("post_rst_q", 32'(q), 32'h50);
    req = 4'b0000;
    repeat (4) step();

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
